regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the Ember core: NULL (index 0, hard-wired zero), G0..G(N-1), SF, LR, SP.
- Adds configurable read and write port counts, a per-register busy scoreboard for issue/writeback tracking, a deterministic write-port priority, and an asynchronous active-low reset.
- Sits between decode/issue (reads and busy checks) and writeback (writes).

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 34, total registers including NULL; SF = NUM_REGS-3, LR = NUM_REGS-2, SP = NUM_REGS-1.
- REG_ADDR_W, 6, register address width; NUM_REGS <= 2**REG_ADDR_W.
- NUM_RD, 3, number of read ports (>=1).
- NUM_WR, 2, number of write ports (>=1).
- SP_RESET, 64'h000000000000FFFF, SP value after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*REG_ADDR_W  write addresses; port k occupies slice k.
- wr_data  input  NUM_WR*DATA_W  write data; port k occupies slice k.
- rd_addr  input  NUM_RD*REG_ADDR_W  read addresses.
- rd_data  output  NUM_RD*DATA_W  read data, combinational.
- rd_busy  output  NUM_RD  busy bit of the addressed register, combinational.
- iss_en  input  1  issue: mark destination pending.
- iss_addr  input  REG_ADDR_W  destination register being issued.
- busy_cnt  output  REG_ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, except SP = SP_RESET.
  - all busy bits = 0; busy_cnt = 0.
  - takes effect immediately, also mid-cycle, and overrides any write or issue.
- Writes:
  - on posedge, port k with wr_en[k]=1, addr != 0 and addr < NUM_REGS writes regs[addr] <= data.
  - addr = 0 or addr >= NUM_REGS: write ignored, no state change.
- Write collision (two enabled ports, same address): the highest-numbered port wins; lower ports are dropped silently.
- Scoreboard, evaluated on posedge:
  - an accepted write clears busy[addr].
  - iss_en=1 with 0 < iss_addr < NUM_REGS sets busy[iss_addr]; otherwise iss_en is ignored.
  - issue and write to the same register in the same cycle: set wins, so busy stays 1 (the newer producer).
- busy_cnt: population count of busy[], registered; it reflects the busy state after the same edge.
- Reads:
  - rd_data[k] = regs[rd_addr[k]].
  - rd_addr = 0 or rd_addr >= NUM_REGS returns 0 and rd_busy 0.
  - without bypass, a read of a register written this cycle returns the old value.
- busy[0] is always 0.
- Latency: write visible on reads 1 cycle after the edge (0 cycles with bypass). Busy set/clear visible 1 cycle after the edge.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - rd_data[k] returns wr_data of the winning (highest) enabled write port whose valid address matches rd_addr[k] in the same cycle.
  - rd_busy[k] reads 0 when that same-cycle write matches, unless iss_en targets the same register this cycle.
- REGFILE_BYPASS_EN undefined: reads return stored contents only and rd_busy reflects stored busy[] only.

Test Plan:
- Reset: assert rst=0 mid-cycle, release -> SP=16'hFFFF, G0/SF/LR = 0, all rd_busy=0, busy_cnt=0.
- Write G5=64'hDEADBEEF on port 0; next cycle read G5 on all NUM_RD ports -> every port returns DEADBEEF. Write to addr 0 -> read 0 still 0. Write to addr 40 -> no register changes.
- Collision: port0 writes G3=1, port1 writes G3=2 in the same cycle -> G3=2.
- Scoreboard sequence:
  - issue G7 -> rd_busy=1, busy_cnt=1.
  - write G7 -> busy 0, count 0.
  - issue G7 and write G7 together -> busy 1.
- Bypass (REGFILE_BYPASS_EN): write G9=0xAA while reading G9 in the same cycle -> rd_data=0xAA. Without the macro -> old value, then 0xAA the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard (NULL hard-wired to zero, SP resets to SP_RESET).
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int                DATA_W     = 64,
  parameter int                NUM_REGS   = 34,
  parameter int                REG_ADDR_W = 6,
  parameter int                NUM_RD     = 3,
  parameter int                NUM_WR     = 2,
  parameter logic [DATA_W-1:0] SP_RESET   = 64'h000000000000FFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*REG_ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         iss_en,
  input  logic [REG_ADDR_W-1:0]        iss_addr,
  output logic [REG_ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [REG_ADDR_W:0] cnt_nxt;

  // NULL and out-of-range addresses are never stored, marked busy or read back.
  function automatic logic addr_ok(input logic [REG_ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Ports are applied in ascending order so the highest enabled port wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[NUM_REGS-1] <= SP_RESET;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && addr_ok(wr_addr[k*REG_ADDR_W +: REG_ADDR_W]))
          regs[wr_addr[k*REG_ADDR_W +: REG_ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Issue is applied after writeback clears so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && addr_ok(wr_addr[k*REG_ADDR_W +: REG_ADDR_W]))
        busy_nxt[wr_addr[k*REG_ADDR_W +: REG_ADDR_W]] = 1'b0;
    end
    if (iss_en && addr_ok(iss_addr)) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{REG_ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [REG_ADDR_W-1:0] ra;
      logic                  hit;
      ra  = rd_addr[k*REG_ADDR_W +: REG_ADDR_W];
      hit = 1'b0;
      if (addr_ok(ra)) begin
        rd_data[k*DATA_W +: DATA_W] = regs[ra];
        rd_busy[k]                  = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*REG_ADDR_W +: REG_ADDR_W] == ra)) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
            hit = 1'b1;
          end
        end
        // A matching write retires the producer unless a new one issues to the same register.
        if (hit) rd_busy[k] = iss_en && (iss_addr == ra);
`else
        hit = 1'b0;
`endif
      end
    end
  end

endmodule
